// File: rtl/run_pattern_gen.sv
// Run-length pattern transmitter: turns {bit, length} commands into a serial
// w stream with a w_valid strobe, reloading back-to-back on the last bit.
module run_pattern_gen #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bit,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             w,
  output logic             w_valid,
  output logic             run_done,
  output logic             busy,
  output logic [CNT_W-1:0] total_bits,
  output logic             state
);

  localparam int RW = LEN_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    remaining_q, remaining_d;
  logic [RW-1:0]    eff_len;
  logic [CNT_W-1:0] total_q;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             last, accept;

  // A length field of zero stands for the longest run, 2^LEN_W.
  assign eff_len = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
  assign last    = (remaining_q == RW'(1));
  assign accept  = cmd_valid & cmd_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else if (enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registers (and enable for the handshake).
  always_comb begin
    cmd_ready = enable & ((state_q == IDLE) | ((state_q == SEND) & last));
    run_done  = w_valid_q & last;
    busy      = (state_q == SEND);
  end

  // Run datapath: load on accept, count down, drop w_valid at run end.
  always_comb begin
    w_d         = w_q;
    w_valid_d   = w_valid_q;
    remaining_d = remaining_q;
    if (accept) begin
      w_d         = cmd_bit;
      w_valid_d   = 1'b1;
      remaining_d = eff_len;
    end else if (state_q == SEND && !last) begin
      remaining_d = remaining_q - RW'(1);
    end else begin
      w_valid_d   = 1'b0;
      remaining_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_q         <= 1'b0;
      w_valid_q   <= 1'b0;
      remaining_q <= '0;
      total_q     <= '0;
    end else if (enable) begin
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      remaining_q <= remaining_d;
      if (w_valid_q) total_q <= total_q + CNT_W'(1);
    end
  end

  assign w          = w_q;
  assign w_valid    = w_valid_q;
  assign total_bits = total_q;
  assign state      = state_q;

endmodule

// File: doc/run_pattern_gen.md
Name: run_pattern_gen

Overview:
Serial pattern transmitter that produces the single-bit `w` stream consumed by the team's run-length sequence detectors. Each command is a bit value and a run length. Commands are accepted over a valid/ready handshake and serialized one bit per enabled clock, with a qualifying `w_valid` strobe. It sits upstream of the detector FSMs in benches and on the board, turning run-length commands back into a bit stream.

Parameters:
LEN_W, 4, width of cmd_len; the run length counter is LEN_W+1 bits wide.
CNT_W, 8, width of the total_bits counter.

Ports:
clock  in  1  single system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  clock enable; when 0, all registers hold and cmd_ready=0.
cmd_valid  in  1  command present.
cmd_ready  out  1  command can be accepted this cycle.
cmd_bit  in  1  bit value to transmit.
cmd_len  in  LEN_W  run length; 0 encodes 2^LEN_W.
w  out  1  serial output bit (registered).
w_valid  out  1  w is a live bit this cycle (registered).
run_done  out  1  current w is the last bit of the run.
busy  out  1  state==SEND.
total_bits  out  CNT_W  count of bits presented with w_valid=1; wraps modulo 2^CNT_W.
state  out  1  current state (IDLE=0, SEND=1), for debug.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-run):
  - state=IDLE, w=0, w_valid=0, remaining=0, total_bits=0.
  - Any in-flight run is discarded.
- Handshake:
  - accept = cmd_valid & cmd_ready, sampled at posedge.
  - cmd_ready = enable & (state==IDLE | (state==SEND & remaining==1)). This is combinational from registers and enable.
  - Command inputs must hold stable while cmd_valid=1 and not accepted.
- Effective length: L = cmd_len, or 2^LEN_W when cmd_len==0.
- IDLE:
  - On accept: w<=cmd_bit, remaining<=L, w_valid<=1, state<=SEND.
  - Otherwise w holds its last value and w_valid=0.
  - Latency: the first bit appears on w one clock after accept.
- SEND, per posedge with enable=1:
  - If remaining>1: remaining<=remaining-1; w unchanged.
  - If remaining==1 and accept: back-to-back reload with no bubble. w<=new cmd_bit, remaining<=new L, w_valid stays 1.
  - If remaining==1 and no accept: state<=IDLE, w_valid<=0, remaining<=0.
- enable=0:
  - All registers hold, including remaining, w, w_valid and total_bits.
  - cmd_ready=0, so no accept can occur.
  - The bit currently shown on w is extended, and downstream must also use enable.
- run_done = w_valid & (remaining==1). It is combinational from registers and is high for exactly one enabled cycle per run.
- total_bits increments by 1 on each enabled posedge where w_valid=1. It wraps 2^CNT_W-1 -> 0.
- A run of length 1 gives a single w_valid cycle with run_done=1.
- Consecutive commands with the same cmd_bit give a continuous run of total length L1+L2 on w.
- No other states exist. An illegal state encoding is not possible with a 1-bit state register.

Test Plan:
1. Reset with reset=0, then release; hold cmd_valid=0 for 5 clocks -> w=0, w_valid=0, cmd_ready=1, total_bits=0, state=0 throughout.
2. Send cmd_bit=1, cmd_len=4 -> w_valid=1 and w=1 for exactly 4 clocks starting one clock after accept. run_done is high on the 4th of those clocks only. Then IDLE, total_bits=4, and a downstream detector fed (enable, w) asserts z after the 4th 1.
3. Back-to-back: {0,len 2} then {1,len 3} with cmd_valid held -> w sequence 0,0,1,1,1 with w_valid continuously high for 5 clocks. cmd_ready is high only on the last bit of the first run; total_bits=5.
4. cmd_len=0 with LEN_W=4 -> 16 consecutive bits of cmd_bit, then run_done on the 16th bit, then IDLE.
5. Drop enable=0 for 3 clocks in the middle of {1,len 4} after 2 bits -> w, w_valid, remaining and total_bits frozen, cmd_ready=0. After enable returns, exactly 2 more bits are sent (4 bits counted in total).
6. Assert reset=0 between clock edges during bit 3 of {0,len 6} -> w_valid and w drop to 0 immediately without waiting for an edge. After release: state=IDLE, total_bits=0, and a new command is accepted normally. Also preload total_bits=255 via 255 single-bit commands, send 1 more -> total_bits=0.
